// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Iterative shift-add multiplier that borrows the shared combinational ALU to
// compute the low XLEN bits of req_a * req_b. While running it owns the ALU
// (alu_own=1) and drives one ADD per multiplier bit; the multiplicand and
// multiplier shifts are done locally.
//
// Optional build macro: MUL_EARLY_EXIT_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero (minimum one RUN cycle). Otherwise RUN always lasts XLEN cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_a, req_b        multiplicand, multiplier
//   kill                abort in-flight operation (pipeline flush)
//   resp_valid/ready    held response handshake
//   resp_data           low XLEN bits of the product
//   alu_own             sequencer owns the ALU this cycle
//   alu_rs1, alu_rs2    ALU operands (accumulator, shifted multiplicand)
//   alu_opcode          ADD_OP while alu_own=1, else 0
//   alu_res             ALU result, combinational in the same cycle

module alu_mul_seq #(
    parameter int          XLEN   = 32,
    parameter logic [4:0]  ADD_OP = 5'b10000,
    parameter int          CNT_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [4:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [XLEN-1:0]   acc_r, acc_nxt_s;
    logic [XLEN-1:0]   mcand_r, mcand_nxt_s;
    logic [XLEN-1:0]   mplier_r, mplier_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [XLEN-1:0]   resp_data_r, resp_data_nxt_s;
    logic [XLEN-1:0]   acc_step_s;
    logic              last_iter_s;
    logic              run_nxt_s;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic              alu_own_r;
    logic [XLEN-1:0]   alu_rs1_r;
    logic [XLEN-1:0]   alu_rs2_r;
    logic [4:0]        alu_opcode_r;

    // Accumulator update for this RUN cycle and detection of the final iteration.
    always_comb begin
        acc_step_s = mplier_r[0] ? alu_res : acc_r;
`ifdef MUL_EARLY_EXIT_EN
        // Remaining multiplier bits all zero: further adds cannot change acc.
        last_iter_s = (cnt_r == CNT_W'(XLEN - 1)) ||
                      ((mplier_r >> 1) == {XLEN{1'b0}});
`else
        last_iter_s = (cnt_r == CNT_W'(XLEN - 1));
`endif
    end

    // Next-state and datapath-update logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        mcand_nxt_s     = mcand_r;
        mplier_nxt_s    = mplier_r;
        cnt_nxt_s       = cnt_r;
        resp_data_nxt_s = resp_data_r;
        case (state_r)
            IDLE: begin
                if (req_valid && !kill) begin
                    state_nxt_s  = RUN;
                    acc_nxt_s    = {XLEN{1'b0}};
                    mcand_nxt_s  = req_a;
                    mplier_nxt_s = req_b;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                if (kill) begin
                    state_nxt_s = IDLE;
                end else begin
                    acc_nxt_s    = acc_step_s;
                    mcand_nxt_s  = mcand_r << 1;
                    mplier_nxt_s = mplier_r >> 1;
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        state_nxt_s     = DONE;
                        resp_data_nxt_s = acc_step_s;
                    end else begin
                        state_nxt_s     = RUN;
                    end
                end
            end
            DONE: begin
                if (kill || resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign run_nxt_s = (state_nxt_s == RUN);

    // State, datapath and output registers; outputs decode the next state so
    // that alu_own and the ALU operands are glitch-free flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {XLEN{1'b0}};
            mcand_r      <= {XLEN{1'b0}};
            mplier_r     <= {XLEN{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            resp_data_r  <= {XLEN{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            alu_own_r    <= 1'b0;
            alu_rs1_r    <= {XLEN{1'b0}};
            alu_rs2_r    <= {XLEN{1'b0}};
            alu_opcode_r <= 5'b00000;
        end else begin
            state_r      <= state_nxt_s;
            acc_r        <= acc_nxt_s;
            mcand_r      <= mcand_nxt_s;
            mplier_r     <= mplier_nxt_s;
            cnt_r        <= cnt_nxt_s;
            resp_data_r  <= resp_data_nxt_s;
            req_ready_r  <= (state_nxt_s == IDLE);
            resp_valid_r <= (state_nxt_s == DONE);
            alu_own_r    <= run_nxt_s;
            // Operand flops mirror acc/mcand while running, zero otherwise.
            alu_rs1_r    <= run_nxt_s ? acc_nxt_s   : {XLEN{1'b0}};
            alu_rs2_r    <= run_nxt_s ? mcand_nxt_s : {XLEN{1'b0}};
            alu_opcode_r <= run_nxt_s ? ADD_OP      : 5'b00000;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign alu_own    = alu_own_r;
    assign alu_rs1    = alu_rs1_r;
    assign alu_rs2    = alu_rs2_r;
    assign alu_opcode = alu_opcode_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: table-driven products plus hand-written
// sequences for hold, kill, reset and handshake corner cases. A small ALU
// model (ADD only) closes the loop through alu_rs1/alu_rs2/alu_opcode.

module tb_alu_mul_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            alu_own;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [4:0]      alu_opcode;
    logic [XLEN-1:0] alu_res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[9];

    alu_mul_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_own    (alu_own),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_opcode (alu_opcode),
        .alu_res    (alu_res)
    );

    always #5 clk = ~clk;

    // Shared ALU model: only ADD is meaningful; anything else returns junk.
    assign alu_res = (alu_opcode == 5'b10000) ? (alu_rs1 + alu_rs2) : 32'hDEADBEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycles from acceptance to first resp_valid.
    function automatic int exp_lat(input logic [31:0] b);
        int runs;
`ifdef MUL_EARLY_EXIT_EN
        runs = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) runs = i + 1;
        end
`else
        runs = XLEN;
`endif
        return runs + 1;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"},  32'(req_ready),  32'd1);
        check({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, "_resp_data"},  resp_data,       32'd0);
        check({name, "_alu_own"},    32'(alu_own),    32'd0);
        check({name, "_alu_rs1"},    alu_rs1,         32'd0);
        check({name, "_alu_rs2"},    alu_rs2,         32'd0);
        check({name, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    endtask

    // Issue a request and wait (bounded) for resp_valid.
    task automatic run_to_done(input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int own_cycles, output int op_bad);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid  = 1'b0;
        lat        = 1;
        own_cycles = 0;
        op_bad     = 0;
        while (!resp_valid && lat < 100) begin
            if (alu_own) begin
                own_cycles++;
                if (alu_opcode !== 5'b10000) op_bad++;
            end
            tick();
            lat++;
        end
    endtask

    task automatic retire(input string name);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, "_retire_valid"}, 32'(resp_valid), 32'd0);
        check({name, "_retire_ready"}, 32'(req_ready),  32'd1);
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p);
        int lat, own, bad;
        run_to_done(a, b, lat, own, bad);
        check({name, "_latency"},   32'(lat),        32'(exp_lat(b)));
        check({name, "_own_cyc"},   32'(own),        32'(exp_lat(b) - 1));
        check({name, "_opcode"},    32'(bad),        32'd0);
        check({name, "_data"},      resp_data,       p);
        check({name, "_done_rdy"},  32'(req_ready),  32'd0);
        check({name, "_done_own"},  32'(alu_own),    32'd0);
        retire(name);
    endtask

    initial begin
        int lat, own, bad, seen;
        logic [31:0] ra, rb;

        vecs[0] = '{32'd6,          32'd7,          32'd42};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        vecs[2] = '{32'h80000000,   32'd2,          32'h00000000};
        vecs[3] = '{32'd3,          32'd5,          32'd15};
        vecs[4] = '{32'h00001234,   32'd1,          32'h00001234};
        vecs[5] = '{32'h12345678,   32'd0,          32'h00000000};
        vecs[6] = '{32'h0000FFFF,   32'h0000FFFF,   32'hFFFE0001};
        vecs[7] = '{32'd3,          32'h80000000,   32'h80000000};
        vecs[8] = '{32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE};

        rst        = 1'b1;
        req_valid  = 1'b0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(req_ready), 32'd1);

        // Directed product table.
        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Hold in DONE for 10 cycles with resp_ready low.
        run_to_done(32'h11, 32'h3, lat, own, bad);
        check("hold_lat", 32'(lat), 32'(exp_lat(32'h3)));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data",  resp_data,       32'h33);
            check("hold_ready", 32'(req_ready),  32'd0);
            check("hold_own",   32'(alu_own),    32'd0);
        end
        // Request presented during DONE->IDLE must wait one more cycle.
        req_a      = 32'd2;
        req_b      = 32'd9;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("ret_valid", 32'(resp_valid), 32'd0);
        check("ret_ready", 32'(req_ready),  32'd1);
        check("ret_noacc", 32'(alu_own),    32'd0);
        tick();
        req_valid = 1'b0;
        check("acc_own",   32'(alu_own),    32'd1);
        check("acc_ready", 32'(req_ready),  32'd0);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("acc_lat",  32'(lat),  32'(exp_lat(32'd9)));
        check("acc_data", resp_data, 32'd18);
        retire("acc");

        // kill at RUN cycle 5.
        req_a     = 32'h0000AAAA;
        req_b     = 32'h00007777;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("kill_pre_own", 32'(alu_own), 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_own",   32'(alu_own),    32'd0);
        check("kill_ready", 32'(req_ready),  32'd1);
        check("kill_valid", 32'(resp_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid || alu_own) seen++;
        end
        check("kill_quiet", 32'(seen), 32'd0);
        do_op("after_kill", 32'd3, 32'd5, 32'd15);

        // kill in DONE discards the result.
        run_to_done(32'd7, 32'd7, lat, own, bad);
        check("kdone_valid0", 32'(resp_valid), 32'd1);
        kill       = 1'b1;
        resp_ready = 1'b1;
        tick();
        kill       = 1'b0;
        resp_ready = 1'b0;
        check("kdone_valid", 32'(resp_valid), 32'd0);
        check("kdone_ready", 32'(req_ready),  32'd1);

        // rst mid-RUN.
        req_a     = 32'd100;
        req_b     = 32'hFFFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rst_run_own", 32'(alu_own), 32'd1);
        rst = 1'b1;
        kill = 1'b1;
        tick();
        rst = 1'b0;
        kill = 1'b0;
        check_reset_outputs("rst_run");

        // rst in DONE clears resp_data too.
        run_to_done(32'd5, 32'd5, lat, own, bad);
        check("rst_done_data0", resp_data, 32'd25);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_done");

        // kill together with req_valid in IDLE: nothing accepted.
        req_a     = 32'd9;
        req_b     = 32'd9;
        req_valid = 1'b1;
        kill      = 1'b1;
        tick();
        req_valid = 1'b0;
        kill      = 1'b0;
        check("idle_kill_own",   32'(alu_own),   32'd0);
        check("idle_kill_ready", 32'(req_ready), 32'd1);
        tick();
        check("idle_kill_own2",  32'(alu_own),   32'd0);
        do_op("after_rst", 32'd11, 32'd13, 32'd143);

        // Random operand pairs against the reference product.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
            do_op("rand", ra, rb, ra * rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
